// File: rtl/count_ctrl_pkg.sv
// Shared types for the count-run scheduler: FSM state encoding and default widths.
package count_ctrl_pkg;

  localparam int CNT_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after i_ptr, wrapping.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IW-1:0]      o_idx,
  output logic               o_any
);

  logic [IW-1:0] w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      w_cand = IW'((int'(i_ptr) + off) % NUM_REQ);
      if (!o_any && i_req[w_cand]) begin
        o_any           = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
      end
    end
  end

endmodule

// File: rtl/count_run_scheduler.sv
// Grants one requester at a time a run of LEN enable cycles on a shared counter,
// then reports a one-cycle completion record.
module count_run_scheduler
  import count_ctrl_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int CNT_W   = CNT_W_DEFAULT,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*CNT_W-1:0] req_len,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     abort,
  input  logic [CNT_W-1:0]         cnt_value,
  input  logic                     cnt_max,
  output logic                     cnt_enable,
  output logic                     busy,
  output logic                     done_valid,
  output logic [IDW-1:0]           done_id,
  output logic [CNT_W-1:0]         done_count,
  output logic                     done_max_seen,
  output logic                     done_aborted
);

  state_t             r_state, w_state_next;
  logic [IDW-1:0]     r_rr_ptr, r_id, w_gidx, w_ptr_next;
  logic [NUM_REQ-1:0] w_grant;
  logic               w_any;
  logic [CNT_W-1:0]   r_remaining, w_len_sel;
  logic [CNT_W-1:0]   w_len_arr [NUM_REQ];
  logic               r_max_seen, r_aborted;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_gidx),
    .o_any   (w_any)
  );

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_len
    assign w_len_arr[gi] = req_len[gi*CNT_W +: CNT_W];
  end

  assign w_len_sel  = w_len_arr[w_gidx];
  assign w_ptr_next = (w_gidx == IDW'(NUM_REQ - 1)) ? '0 : w_gidx + IDW'(1);

  always_comb begin
    w_state_next  = r_state;
    req_ready     = '0;
    cnt_enable    = 1'b0;
    busy          = 1'b0;
    done_valid    = 1'b0;
    done_id       = '0;
    done_count    = '0;
    done_max_seen = 1'b0;
    done_aborted  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any && reset_n) begin
          req_ready    = w_grant;
          w_state_next = (w_len_sel == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        cnt_enable = 1'b1;
        busy       = 1'b1;
        if (abort || r_remaining == CNT_W'(1)) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        // The counter already shows the value after the final increment here.
        busy          = 1'b1;
        done_valid    = 1'b1;
        done_id       = r_id;
        done_count    = cnt_value;
        done_max_seen = r_max_seen;
        done_aborted  = r_aborted;
        w_state_next  = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_id        <= '0;
      r_remaining <= '0;
      r_max_seen  <= 1'b0;
      r_aborted   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_id        <= w_gidx;
            r_remaining <= w_len_sel;
            r_rr_ptr    <= w_ptr_next;
            r_max_seen  <= 1'b0;
            r_aborted   <= 1'b0;
          end
        end
        ST_RUN: begin
          r_remaining <= r_remaining - CNT_W'(1);
          r_max_seen  <= r_max_seen | cnt_max;
          if (abort) r_aborted <= 1'b1;
        end
        default: r_remaining <= '0;
      endcase
    end
  end

endmodule
